// File: rtl/joystick_port_mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_port_mapper_pkg
//  Purpose  : Shared constants, types and mapping helpers for the joystick
//             port mapper (modes, joystick bit indices, keyboard rows).
//  Revision : 1.0  initial release
// ============================================================================
package joystick_port_mapper_pkg;

    // Joystick word width: MXYZ SACB RLDU, negative logic
    localparam int JOY_W    = 12;
    localparam int KBD_COLS = 5;

    // Per-joystick presentation modes
    localparam logic [1:0] MODE_KEMPSTON  = 2'b00;
    localparam logic [1:0] MODE_SINCLAIR1 = 2'b01;
    localparam logic [1:0] MODE_SINCLAIR2 = 2'b10;
    localparam logic [1:0] MODE_CURSOR    = 2'b11;

    // Bit positions inside the joystick word
    localparam int JB_U = 0;
    localparam int JB_D = 1;
    localparam int JB_L = 2;
    localparam int JB_R = 3;
    localparam int JB_B = 4;
    localparam int JB_C = 5;
    localparam int JB_A = 6;
    localparam int JB_S = 7;
    localparam int JB_Z = 8;
    localparam int JB_Y = 9;
    localparam int JB_X = 10;
    localparam int JB_M = 11;

    // Address lines that select the two keyboard half-rows (active low)
    localparam int ROW_EFFE_BIT = 12;
    localparam int ROW_F7FE_BIT = 11;

    // Active-high button set after filtering; fire already gated by autofire
    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
        logic fire;
        logic c;
        logic a;
    } joy_btn_t;

    // Active-high key contributions for the two half-rows
    typedef struct packed {
        logic [KBD_COLS-1:0] effe;
        logic [KBD_COLS-1:0] f7fe;
    } kbd_rows_t;

    // Kempston byte: bit0 R, bit1 L, bit2 D, bit3 U, bit4 fire, bit5 C, bit6 A
    function automatic logic [7:0] kemp_byte(input joy_btn_t b);
        return {1'b0, b.a, b.c, b.fire, b.u, b.d, b.l, b.r};
    endfunction

    // Key contributions of one joystick, given its mode
    function automatic kbd_rows_t kbd_rows(input logic [1:0] mode,
                                           input logic u, input logic d,
                                           input logic l, input logic r,
                                           input logic fire);
        kbd_rows_t rows;
        rows = '0;
        case (mode)
            MODE_SINCLAIR1: rows.effe = {l, r, d, u, fire};
            MODE_SINCLAIR2: rows.f7fe = {fire, u, d, r, l};
            MODE_CURSOR: begin
                rows.effe = {d, u, r, 1'b0, fire};
                rows.f7fe = {l, 4'b0000};
            end
            default: rows = '0;
        endcase
        return rows;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joystick_port_mapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_port_mapper_if
//  Purpose  : CPU-side bus between the Spectrum core and the joystick mapper.
//  Signals  : addr/iorq_n/rd_n   CPU address and I/O read strobes
//             kemp_data/kemp_oe  Kempston byte and its output enable
//             kbd_cols_n         key columns merged into ULA port FE (0 = key)
//  Modports : master = CPU side, slave = mapper side
//  Revision : 1.0  initial release
// ============================================================================
interface joystick_port_mapper_if;
    import joystick_port_mapper_pkg::*;

    logic [15:0]         addr;
    logic                iorq_n;
    logic                rd_n;
    logic [7:0]          kemp_data;
    logic                kemp_oe;
    logic [KBD_COLS-1:0] kbd_cols_n;

    modport master (
        output addr, iorq_n, rd_n,
        input  kemp_data, kemp_oe, kbd_cols_n
    );

    modport slave (
        input  addr, iorq_n, rd_n,
        output kemp_data, kemp_oe, kbd_cols_n
    );
endinterface
`default_nettype wire

// File: rtl/joystick_port_mapper_joy_stable_filter.sv
`default_nettype none
// ============================================================================
//  Module   : joy_stable_filter
//  Purpose  : Accepts a joystick word only once it has been unchanged for
//             DEB_CYCLES consecutive clocks; the accepted word moves
//             DEB_CYCLES+1 clocks after the new value first appears.
//  Ports    : clk, reset_n (async, active low)
//             i_joy   raw joystick word (0 = pressed)
//             o_filt  accepted joystick word
//  Revision : 1.0  initial release
// ============================================================================
module joy_stable_filter
    import joystick_port_mapper_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JOY_W-1:0] i_joy,
    output logic [JOY_W-1:0] o_filt
);

    localparam logic [7:0] c_CNT_LAST = 8'(DEB_CYCLES - 1);

    logic [JOY_W-1:0] r_cand;
    logic [7:0]       r_cnt;
    logic [JOY_W-1:0] r_filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand <= '1;
            r_cnt  <= 8'd0;
            r_filt <= '1;
        end else if (i_joy != r_cand) begin
            r_cand <= i_joy;
            r_cnt  <= 8'd0;
        end else if (r_cnt == c_CNT_LAST) begin
            // Counter parks here; re-loading the same word is harmless
            r_filt <= r_cand;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/joystick_port_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_port_mapper
//  Purpose  : Maps two filtered Megadrive/passive joystick words onto a
//             Kempston port and Sinclair1/Sinclair2/Cursor key presses, with
//             frame-locked autofire on the B button.
//  Ports    : clk, reset_n (async, active low)
//             joy1_i/joy2_i        raw joystick words (0 = pressed)
//             joy1_mode/joy2_mode  00 Kempston, 01 Sinc1, 10 Sinc2, 11 Cursor
//             joy1_af_en/joy2_af_en autofire enable per joystick
//             vsync_n              video vsync, falling edge paces autofire
//             bus                  CPU bus (slave modport)
//  Revision : 1.0  initial release
// ============================================================================
module joystick_port_mapper
    import joystick_port_mapper_pkg::*;
#(
    parameter int         DEB_CYCLES = 16,
    parameter int         AF_FRAMES  = 4,
    parameter logic [7:0] KEMP_ADDR  = 8'h1F
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JOY_W-1:0] joy1_i,
    input  logic [JOY_W-1:0] joy2_i,
    input  logic [1:0]       joy1_mode,
    input  logic [1:0]       joy2_mode,
    input  logic             joy1_af_en,
    input  logic             joy2_af_en,
    input  logic             vsync_n,
    joystick_port_mapper_if.slave bus
);

    localparam logic [3:0] c_AF_LAST = 4'(AF_FRAMES - 1);

    // ---------------- autofire timebase (shared) ----------------
    logic       r_vs_d;
    logic [3:0] r_af_cnt;
    logic       r_af_phase;
    logic       w_vs_fall;

    assign w_vs_fall = r_vs_d & ~vsync_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d     <= 1'b1;
            r_af_cnt   <= 4'd0;
            r_af_phase <= 1'b0;
        end else begin
            r_vs_d <= vsync_n;
            if (w_vs_fall) begin
                if (r_af_cnt == c_AF_LAST) begin
                    r_af_cnt   <= 4'd0;
                    r_af_phase <= ~r_af_phase;
                end else begin
                    r_af_cnt   <= r_af_cnt + 4'd1;
                end
            end
        end
    end

    // ---------------- per-joystick path ----------------
    logic [1:0][JOY_W-1:0] w_joy_in;
    logic [1:0][1:0]       w_mode;
    logic [1:0]            w_af_en;
    logic [15:0]           w_kemp_bytes;   // byte per joystick, zero unless Kempston
    logic [9:0]            w_effe_cols;
    logic [9:0]            w_f7fe_cols;

    assign w_joy_in = {joy2_i, joy1_i};
    assign w_mode   = {joy2_mode, joy1_mode};
    assign w_af_en  = {joy2_af_en, joy1_af_en};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_joy
        logic [JOY_W-1:0] w_filt;
        logic             w_fire;
        joy_btn_t         w_btn;
        kbd_rows_t        w_rows;
        logic             w_unused_hi;

        joy_stable_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
            .clk     (clk),
            .reset_n (reset_n),
            .i_joy   (w_joy_in[gi]),
            .o_filt  (w_filt)
        );

        // With autofire on, a held B only counts during the high phase
        assign w_fire = ~w_filt[JB_B] & (w_af_en[gi] ? r_af_phase : 1'b1);

        assign w_btn = joy_btn_t'({~w_filt[JB_U], ~w_filt[JB_D], ~w_filt[JB_L],
                                   ~w_filt[JB_R], w_fire,
                                   ~w_filt[JB_C], ~w_filt[JB_A]});

        assign w_rows = kbd_rows(w_mode[gi], w_btn.u, w_btn.d, w_btn.l,
                                 w_btn.r, w_btn.fire);

        assign w_kemp_bytes[gi*8 +: 8] = (w_mode[gi] == MODE_KEMPSTON) ?
                                         kemp_byte(w_btn) : 8'h00;
        assign w_effe_cols[gi*5 +: 5]  = w_rows.effe;
        assign w_f7fe_cols[gi*5 +: 5]  = w_rows.f7fe;

        // S, Z, Y, X, M have no destination on the Spectrum side
        assign w_unused_hi = &{w_filt[JB_M], w_filt[JB_X], w_filt[JB_Y],
                               w_filt[JB_Z], w_filt[JB_S]};
    end

    // ---------------- Kempston port ----------------
    logic       w_sel;
    logic [7:0] w_kemp_mix;
    logic [7:0] r_kemp_data;
    logic       r_kemp_oe;

    assign w_sel      = ~bus.iorq_n & ~bus.rd_n & (bus.addr[7:0] == KEMP_ADDR);
    assign w_kemp_mix = w_kemp_bytes[7:0] | w_kemp_bytes[15:8];

    // Latch once per IN cycle so the CPU sees a stable byte for the whole read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kemp_data <= 8'h00;
            r_kemp_oe   <= 1'b0;
        end else if (w_sel && !r_kemp_oe) begin
            r_kemp_data <= w_kemp_mix;
            r_kemp_oe   <= 1'b1;
        end else if (!w_sel) begin
            r_kemp_oe   <= 1'b0;
        end
    end

    assign bus.kemp_data = r_kemp_data;
    assign bus.kemp_oe   = r_kemp_oe;

    // ---------------- keyboard overlay ----------------
    logic [KBD_COLS-1:0] w_cols;
    logic                w_unused_addr;

    assign w_cols = ({KBD_COLS{~bus.addr[ROW_EFFE_BIT]}} &
                     (w_effe_cols[4:0] | w_effe_cols[9:5])) |
                    ({KBD_COLS{~bus.addr[ROW_F7FE_BIT]}} &
                     (w_f7fe_cols[4:0] | w_f7fe_cols[9:5]));

    assign bus.kbd_cols_n = ~w_cols;

    assign w_unused_addr = &{bus.addr[15:13], bus.addr[10:8]};

endmodule
`default_nettype wire
